// File: rtl/navic_prn_pkg.sv
// Shared constants, state encoding and Gold-code helpers for the NavIC PRN sequencer.
package navic_prn_pkg;

  localparam int NUM_SV   = 64;
  localparam int SV_W     = 6;
  localparam int CODE_LEN = 1023;
  localparam int EPOCH_W  = 8;
  localparam int IDX_W    = 10;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

  // Vectors indexed [0:9]: bit i is shift-register stage i+1.
  localparam logic [0:9] G1_INIT = 10'b11_1111_1111;
  localparam logic [0:9] G1_TAPS = 10'b00_1000_0001;  // stages 3,10
  localparam logic [0:9] G2_TAPS = 10'b01_1001_0111;  // stages 2,3,6,8,9,10

  localparam logic BAND_L5 = 1'b0;
  localparam logic BAND_S  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // One LFSR shift: tap parity enters stage 1, everything moves toward stage 10.
  function automatic logic [0:9] lfsr_next(input logic [0:9] stages, input logic [0:9] taps);
    return {^(stages & taps), stages[0:8]};
  endfunction

  // Seed-table row for a band.
  function automatic logic band_row(input logic band);
    logic row;
    case (band)
      BAND_L5: row = 1'b0;
      BAND_S:  row = 1'b1;
      default: row = 1'b0;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/navic_prn_if.sv
// Configuration, request and chip-stream signals between scheduler/correlator and the sequencer.
interface navic_prn_if;
  import navic_prn_pkg::*;

  logic               cfg_we;
  logic               cfg_band;
  logic [SV_W-1:0]    cfg_addr;
  logic [0:9]         cfg_seed;
  logic               req_valid;
  logic               req_ready;
  logic [SV_W-1:0]    req_sv;
  logic               req_band;
  logic [EPOCH_W-1:0] req_epochs;
  logic               abort;
  logic               chip_valid;
  logic               chip_ready;
  logic               chip;
  logic [IDX_W-1:0]   chip_idx;
  logic               epoch_start;
  logic               epoch_end;
  logic               busy;
  logic               done;

  modport master (
    output cfg_we, cfg_band, cfg_addr, cfg_seed,
    output req_valid, req_sv, req_band, req_epochs, abort, chip_ready,
    input  req_ready, chip_valid, chip, chip_idx, epoch_start, epoch_end, busy, done
  );

  modport slave (
    input  cfg_we, cfg_band, cfg_addr, cfg_seed,
    input  req_valid, req_sv, req_band, req_epochs, abort, chip_ready,
    output req_ready, chip_valid, chip, chip_idx, epoch_start, epoch_end, busy, done
  );
endinterface

// File: rtl/navic_gold_lfsr.sv
// G1/G2 Gold-code generator: load a seed, step one chip, or rewind to the latched seed.
module navic_gold_lfsr
  import navic_prn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       reload,
  input  logic       step,
  input  logic [0:9] seed,
  output logic       chip
);

  logic [0:9] g1_r;
  logic [0:9] g2_r;
  logic [0:9] seed_lat_r;

  // Generator registers: fresh load latches the seed so later table writes cannot disturb the run
  always_ff @(posedge clk) begin
    if (rst) begin
      g1_r       <= 10'b0;
      g2_r       <= 10'b0;
      seed_lat_r <= 10'b0;
    end else if (load) begin
      g1_r       <= G1_INIT;
      g2_r       <= seed;
      seed_lat_r <= seed;
    end else if (reload) begin
      g1_r <= G1_INIT;
      g2_r <= seed_lat_r;
    end else if (step) begin
      g1_r <= lfsr_next(g1_r, G1_TAPS);
      g2_r <= lfsr_next(g2_r, G2_TAPS);
    end
  end

  assign chip = g1_r[9] ^ g2_r[9];

endmodule

// File: rtl/navic_prn_sequencer.sv
// Time-shared PRN sequencer: seed table, request FSM, epoch/chip counters and chip-stream handshake.
module navic_prn_sequencer
  import navic_prn_pkg::*;
(
  input logic        clk,
  input logic        rst,
  navic_prn_if.slave bus
);

  state_e             state_r;
  state_e             state_nx_s;
  logic [0:9]         seed_tab_r [2*NUM_SV];
  logic [SV_W-1:0]    sv_r;
  logic               band_r;
  logic [EPOCH_W-1:0] epochs_r;
  logic [EPOCH_W-1:0] epoch_cnt_r;
  logic [0:9]         seed_rd_r;
  logic [IDX_W-1:0]   chip_idx_r;

  logic req_ready_s, chip_valid_s, busy_s, done_s, lfsr_load_s;
  logic xfer_s, last_chip_s, final_s, lfsr_chip_s;

  // A chip is transferred only when presented, accepted and not aborted in the same cycle.
  assign xfer_s      = chip_valid_s & bus.chip_ready & ~bus.abort;
  assign last_chip_s = (chip_idx_r == LAST_IDX);
  assign final_s     = xfer_s & last_chip_s & (epoch_cnt_r == EPOCH_W'(1));

  // Seed table write port: usable in any state, deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      seed_tab_r[{band_row(bus.cfg_band), bus.cfg_addr}] <= bus.cfg_seed;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state and per-state control decode
  always_comb begin
    state_nx_s   = state_r;
    req_ready_s  = 1'b0;
    chip_valid_s = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    lfsr_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (bus.req_valid) state_nx_s = ST_FETCH;
        else               state_nx_s = ST_IDLE;
      end
      ST_FETCH: begin
        busy_s = 1'b1;
        if (bus.abort) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_LOAD;
      end
      ST_LOAD: begin
        busy_s = 1'b1;
        if (bus.abort) begin
          state_nx_s = ST_IDLE;
        end else begin
          lfsr_load_s = 1'b1;
          state_nx_s  = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_s       = 1'b1;
        chip_valid_s = 1'b1;
        if (bus.abort)    state_nx_s = ST_IDLE;
        else if (final_s) state_nx_s = ST_DONE;
        else              state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        done_s     = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Request latch, synchronous table read and chip/epoch counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_r        <= '0;
      band_r      <= 1'b0;
      epochs_r    <= '0;
      epoch_cnt_r <= '0;
      seed_rd_r   <= 10'b0;
      chip_idx_r  <= '0;
    end else begin
      if (req_ready_s && bus.req_valid) begin
        sv_r     <= bus.req_sv;
        band_r   <= bus.req_band;
        epochs_r <= bus.req_epochs;
      end
      if (state_r == ST_FETCH) begin
        seed_rd_r <= seed_tab_r[{band_row(band_r), sv_r}];
      end
      if (lfsr_load_s) begin
        chip_idx_r  <= '0;
        epoch_cnt_r <= epochs_r;
      end else if (xfer_s) begin
        if (last_chip_s) begin
          chip_idx_r <= '0;
          // A zero count means continuous: it never decrements, so it never reaches one.
          if (epoch_cnt_r != '0) epoch_cnt_r <= epoch_cnt_r - EPOCH_W'(1);
        end else begin
          chip_idx_r <= chip_idx_r + IDX_W'(1);
        end
      end
    end
  end

  navic_gold_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load_s),
    .reload (xfer_s & last_chip_s),
    .step   (xfer_s & ~last_chip_s),
    .seed   (seed_rd_r),
    .chip   (lfsr_chip_s)
  );

  // Chip-side outputs are forced quiet outside RUN so idle/reset values are clean.
  assign bus.req_ready   = req_ready_s;
  assign bus.chip_valid  = chip_valid_s;
  assign bus.chip        = chip_valid_s & lfsr_chip_s;
  assign bus.chip_idx    = chip_valid_s ? chip_idx_r : '0;
  assign bus.epoch_start = chip_valid_s & (chip_idx_r == '0);
  assign bus.epoch_end   = chip_valid_s & last_chip_s;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;

endmodule
